// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU; one operation in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Req0_Valid,
  output logic             Req0_Ready,
  input  logic [WIDTH-1:0] Req0_A,
  input  logic [WIDTH-1:0] Req0_B,
  input  logic [3:0]       Req0_Sel,
  input  logic             Req1_Valid,
  output logic             Req1_Ready,
  input  logic [WIDTH-1:0] Req1_A,
  input  logic [WIDTH-1:0] Req1_B,
  input  logic [3:0]       Req1_Sel,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_Sel,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic             ALU_Zero,
  output logic             Rsp0_Valid,
  input  logic             Rsp0_Ready,
  output logic             Rsp1_Valid,
  input  logic             Rsp1_Ready,
  output logic [WIDTH-1:0] Rsp_Data,
  output logic             Rsp_Zero,
  output logic             Busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, data_q;
  logic [3:0]       sel_q;
  logic             owner_q, zero_q;
  logic             grant1, handshake, rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant1 = Req1_Valid & ~Req0_Valid;
  end
`else
  // last_q = 1 means requester 1 was granted last, so requester 0 wins the next contention.
  logic last_q;

  always_comb begin
    grant1 = Req1_Valid & (~Req0_Valid | ~last_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (handshake) begin
      last_q <= grant1;
    end
  end
`endif

  always_comb begin
    Req0_Ready = (state_q == StIdle) & Req0_Valid & ~grant1;
    Req1_Ready = (state_q == StIdle) & grant1;
    handshake  = Req0_Ready | Req1_Ready;
    rsp_ready  = owner_q ? Rsp1_Ready : Rsp0_Ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 4'b0000;
      owner_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (handshake) begin
            a_q     <= grant1 ? Req1_A : Req0_A;
            b_q     <= grant1 ? Req1_B : Req0_B;
            sel_q   <= grant1 ? Req1_Sel : Req0_Sel;
            owner_q <= grant1;
            state_q <= StExec;
          end
        end
        StExec: begin
          data_q  <= ALU_Result;
          zero_q  <= ALU_Zero;
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Operand registers drive the ALU in every state so its inputs never glitch.
  assign ALU_A      = a_q;
  assign ALU_B      = b_q;
  assign ALU_Sel    = sel_q;
  assign Rsp0_Valid = (state_q == StResp) & ~owner_q;
  assign Rsp1_Valid = (state_q == StResp) & owner_q;
  assign Rsp_Data   = data_q;
  assign Rsp_Zero   = zero_q;
  assign Busy       = (state_q != StIdle);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 Reqn_Valid  input  1  (n=0,1) requester n has an operation pending.
REQ-005 Reqn_Ready  output  1  (n=0,1) arbiter accepts requester n this cycle.
REQ-006 Reqn_A, Reqn_B  input  WIDTH  (n=0,1) operands.
REQ-007 Reqn_Sel  input  4  (n=0,1) 4-bit ALU select code, same encoding as the core ALU.
REQ-008 ALU_A, ALU_B  output  WIDTH  operands driven to the shared ALU.
REQ-009 ALU_Sel  output  4  select driven to the shared ALU.
REQ-010 ALU_Result  input  WIDTH  combinational result from the shared ALU.
REQ-011 ALU_Zero  input  1  zero flag from the shared ALU.
REQ-012 Rspn_Valid  output  1  (n=0,1) result for requester n available.
REQ-013 Rspn_Ready  input  1  (n=0,1) requester n consumes the result.
REQ-014 Rsp_Data  output  WIDTH  captured result, shared by both response channels.
REQ-015 Rsp_Zero  output  1  captured zero flag.
REQ-016 Busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, EXEC, RESP; exactly one operation in flight.
REQ-018 IDLE: Reqn_Ready high only for the granted requester, and only when its Reqn_Valid is high; both Ready low in EXEC/RESP.
REQ-019 Handshake Reqn_Valid&Reqn_Ready latches Reqn_A/B/Sel into operand registers, records grant owner, IDLE->EXEC.
REQ-020 Requester inputs are sampled only at the handshake edge; changes at other times have no effect.
REQ-021 EXEC: ALU_A/B/Sel driven from operand registers; ALU_Result/ALU_Zero captured into Rsp_Data/Rsp_Zero at end of cycle; EXEC->RESP unconditionally.
REQ-022 RESP: Rspn_Valid high for the owner only; held with Rsp_Data stable until Rspn_Ready; on Rspn_Valid&Rspn_Ready, RESP->IDLE.
REQ-023 Latency: handshake edge T, Rspn_Valid asserted from cycle T+2; minimum back-to-back issue interval 3 cycles.
REQ-024 Default arbitration round-robin: sole valid requester is granted; if both are valid, grant the requester not granted last.
REQ-025 Last-grant pointer updates only on a handshake.
REQ-026 ALU_A/B/Sel hold operand-register values in all states (no glitching to zero in IDLE).
REQ-027 Rsp_Data/Rsp_Zero change only on the EXEC capture edge.
REQ-028 Rspn_Ready asserted outside RESP or for the non-owner is ignored.

Reset
REQ-029 rst low asynchronously forces IDLE; Reqn_Ready follows REQ-018 once released.
REQ-030 Reset values: operand registers, Rsp_Data 0; ALU_Sel 4'b0000; Rsp_Zero, Rspn_Valid, Busy 0; last-grant pointer = 1, so requester 0 wins first contention.
REQ-031 Reset during EXEC or RESP discards the in-flight operation; no response is produced after release.

Configuration
REQ-032 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins contention; pointer logic absent.
REQ-033 Macro undefined: round-robin per REQ-024/025.

Verification
REQ-034 Req0 only, A=5, B=3, Sel=0000 -> Rsp0_Valid at T+2, Rsp_Data=8, Rsp_Zero=0, Rsp1_Valid stays 0.
REQ-035 Req1 only, A=7, B=7, Sel=0001 -> Rsp1_Valid at T+2, Rsp_Data=0, Rsp_Zero=1.
REQ-036 Both valid continuously from reset, Rspn_Ready tied 1 -> grants alternate 0,1,0,1 (round-robin); all to requester 0 with ALU_ARB_FIXED_PRIO_EN.
REQ-037 Rsp0_Ready held low 5 cycles in RESP -> Rsp0_Valid and Rsp_Data stable throughout, both Reqn_Ready low, Busy=1.
REQ-038 rst pulsed low during EXEC -> Busy=0 and Rspn_Valid=0 immediately; no response after release; next grant goes to requester 0.
